// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: arbiter FSM states and index sizing.
package uart_pkg;

  // Arbiter FSM: ARB picks a requester and latches its byte, SEND presents it
  // to uart_tx until the transmitter accepts it.
  typedef enum logic {
    ARB  = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: scans the request vector starting just
// after the last grant and wrapping around, so the last grant is checked last.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = uart_pkg::idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int cand;

  // First set bit at positions last+1, last+2, ... modulo NUM_REQ.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = IDX_W'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// A single-entry holding register decouples requesters from the transmitter;
// a grant may be kept for up to MAX_BURST consecutive bytes.
//
// Handshakes: a byte moves on a requester port in the ARB cycle where
// req_ready[i] is high (req_valid[i] is already high by construction); a byte
// moves to uart_tx on the rising edge where tx_valid && tx_ready. Requesters
// must hold req_valid/req_data until accepted; tx_valid/tx_data stay stable
// until tx_ready is seen. req_ready depends only on state, req_valid,
// grant_id and burst_cnt, never on tx_ready. busy mirrors the FSM state
// (high exactly in SEND).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 tx_valid,
  output logic [DATA_WIDTH-1:0]                tx_data,
  input  logic                                 tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 busy
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_t           state;
  logic [BURST_W-1:0]   burst_cnt;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 continuing;
  logic [NUM_REQ-1:0]   keep_onehot;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req_valid),
    .last   (grant_id),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Burst continuation: keep the current grant while it is mid-burst and
  // still has a byte; otherwise fall back to the rotating picker.
  always_comb begin
    continuing = (burst_cnt != '0) &&
                 (burst_cnt < BURST_W'(MAX_BURST)) &&
                 req_valid[grant_id];
    keep_onehot           = '0;
    keep_onehot[grant_id] = 1'b1;
    win_onehot = continuing ? keep_onehot : pick_onehot;
    win_idx    = continuing ? grant_id    : pick_idx;
    win_any    = continuing | pick_any;
  end

  // Mealy accept pulse: only in ARB, never during reset, one-hot by construction.
  always_comb begin
    req_ready = '0;
    if (state == ARB && !rst && win_any) begin
      req_ready = win_onehot;
    end
  end

  assign busy = (state == SEND);

  // Arbiter FSM with registered transmitter outputs and burst bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      grant_id  <= IDX_W'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (win_any) begin
            tx_data   <= req_data[win_idx];
            tx_valid  <= 1'b1;
            grant_id  <= win_idx;
            burst_cnt <= continuing ? (burst_cnt + BURST_W'(1)) : BURST_W'(1);
            state     <= SEND;
          end else begin
            burst_cnt <= '0;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ARB;
          end
        end
        default: begin
          state    <= ARB;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (DATA_WIDTH=8, NUM_REQ=4, MAX_BURST=4).
module tb_uart_tx_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic                  clk;
  logic                  rst;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0][DW-1:0] req_data;
  logic [NR-1:0]         req_ready;
  logic                  tx_valid;
  logic [DW-1:0]         tx_data;
  logic                  tx_ready;
  logic [1:0]            grant_id;
  logic                  busy;

  int n_cmp;
  int n_err;
  logic [DW-1:0] exp_q[$];

  uart_tx_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Clock and reset default
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver helpers: inputs change 1 time unit after a rising edge,
  // outputs are sampled on the falling edge.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    req_valid = '0;
    repeat (cycles) after_edge();
    rst = 1'b0;
  endtask

  initial begin
    int cnt [NR];
    int seen;
    int budget;
    logic [NR-1:0] acc;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    tx_ready = 1'b1;
    req_valid = 4'hF;
    req_data = {8'h30, 8'h20, 8'h10, 8'h00};

    // ---- reset held 3 cycles with all requesters valid
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    after_edge();
    rst = 1'b0;
    sample();
    chk("first_grant_ready", 32'(req_ready), 32'h1);
    chk("first_grant_busy", 32'(busy), 32'd0);
    after_edge();
    req_valid = '0;
    sample();
    chk("first_tx_valid", 32'(tx_valid), 32'd1);
    chk("first_tx_data", 32'(tx_data), 32'h00);
    chk("first_grant_id", 32'(grant_id), 32'd0);
    chk("first_busy", 32'(busy), 32'd1);
    chk("first_no_ready_in_send", 32'(req_ready), 32'd0);
    after_edge();
    sample();
    chk("first_done_tx_valid", 32'(tx_valid), 32'd0);
    chk("first_done_busy", 32'(busy), 32'd0);

    // ---- single byte from requester 1
    after_edge();
    req_valid = 4'b0010;
    req_data[1] = 8'hA5;
    sample();
    chk("single_ready", 32'(req_ready), 32'b0010);
    after_edge();
    req_valid = '0;
    sample();
    chk("single_ready_gone", 32'(req_ready), 32'd0);
    chk("single_tx_valid", 32'(tx_valid), 32'd1);
    chk("single_tx_data", 32'(tx_data), 32'hA5);
    chk("single_grant_id", 32'(grant_id), 32'd1);
    after_edge();
    sample();
    chk("single_tx_valid_drop", 32'(tx_valid), 32'd0);
    chk("single_idle_ready", 32'(req_ready), 32'd0);

    // ---- full contention, bursts of 4, order 00-03,10-13,20-23,30-33,04-07
    do_reset(2);
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NR; r++)
        for (int k = 0; k < MB; k++)
          if (!(b == 1 && r > 0)) exp_q.push_back(DW'(16 * r + 4 * b + k));
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    seen = 0;
    budget = 100;
    while (seen < 20 && budget > 0) begin
      req_valid = 4'hF;
      for (int i = 0; i < NR; i++) req_data[i] = DW'(16 * i + cnt[i]);
      sample();
      acc = req_ready;
      chk("cont_onehot", 32'(acc & (acc - 1'b1)), 32'd0);
      if (tx_valid && tx_ready) begin
        chk("cont_order", 32'(tx_data), 32'(exp_q.pop_front()));
        seen++;
      end
      after_edge();
      for (int i = 0; i < NR; i++) if (acc[i]) cnt[i]++;
      budget--;
    end
    chk("cont_bytes_seen", 32'(seen), 32'd20);
    req_valid = '0;
    exp_q.delete();

    // ---- short burst: requester 0 sends 2 bytes, requester 2 waits
    do_reset(2);
    req_valid = 4'b0101;
    req_data[0] = 8'hB0;
    req_data[2] = 8'hC0;
    sample();
    chk("short_ready0_a", 32'(req_ready), 32'b0001);
    after_edge();
    req_data[0] = 8'hB1;
    sample();
    chk("short_tx_b0", 32'(tx_data), 32'hB0);
    after_edge();
    sample();
    chk("short_ready0_b", 32'(req_ready), 32'b0001);
    after_edge();
    req_valid = 4'b0100;
    sample();
    chk("short_tx_b1", 32'(tx_data), 32'hB1);
    after_edge();
    sample();
    chk("short_ready2", 32'(req_ready), 32'b0100);
    after_edge();
    req_valid = '0;
    sample();
    chk("short_tx_c0", 32'(tx_data), 32'hC0);
    chk("short_grant2", 32'(grant_id), 32'd2);
    after_edge();

    // ---- backpressure: 50 cycles of tx_ready low in SEND
    tx_ready = 1'b0;
    req_valid = 4'b1010;
    req_data[1] = 8'h5A;
    req_data[3] = 8'h77;
    sample();
    chk("bp_ready3", 32'(req_ready), 32'b1000);
    after_edge();
    req_valid = 4'b0010;
    for (int i = 0; i < 50; i++) begin
      sample();
      chk("bp_tx_valid", 32'(tx_valid), 32'd1);
      chk("bp_tx_data", 32'(tx_data), 32'h77);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
      after_edge();
    end
    tx_ready = 1'b1;
    sample();
    chk("bp_release_data", 32'(tx_data), 32'h77);
    after_edge();
    sample();
    chk("bp_once_tx_valid", 32'(tx_valid), 32'd0);
    chk("bp_next_ready1", 32'(req_ready), 32'b0010);
    after_edge();
    req_valid = '0;
    tx_ready = 1'b0;
    sample();
    chk("bp_tx_5a", 32'(tx_data), 32'h5A);
    chk("bp_grant1", 32'(grant_id), 32'd1);

    // ---- reset while holding 0x5A in SEND
    after_edge();
    rst = 1'b1;
    sample();
    chk("mid_rst_no_ready", 32'(req_ready), 32'd0);
    after_edge();
    rst = 1'b0;
    tx_ready = 1'b1;
    sample();
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      after_edge();
      sample();
      chk("mid_rst_stays_idle", 32'(tx_valid), 32'd0);
    end
    after_edge();
    req_valid = 4'b0100;
    req_data[2] = 8'h33;
    sample();
    chk("post_rst_ready2", 32'(req_ready), 32'b0100);
    after_edge();
    req_valid = '0;
    sample();
    chk("post_rst_tx_valid", 32'(tx_valid), 32'd1);
    chk("post_rst_tx_data", 32'(tx_data), 32'h33);
    after_edge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
